asi_arbiter: RTL
================

ASI_ARBITER -- requirements
Module: asi_arbiter

Interface
REQ-001 Parameter ASI_ARB, default 0, priority side: 1 = read has priority, 0 = write has priority.
REQ-002 Parameter ARB_STARVE, default 4, range 1..15, maximum consecutive priority-side grants while the other side waits.
REQ-003 usr_clk  input  1  single clock; all state updates on rising edge.
REQ-004 usr_reset  input  1  synchronous, active-high reset.
REQ-005 usr_rrequest  input  1  read-side request: read address buffer holds a not-yet-started burst.
REQ-006 usr_re  input  1  read-side beat strobe.
REQ-007 usr_rlast  input  1  final read beat; qualified by usr_re.
REQ-008 usr_rgrant  output  1  read side owns the user port.
REQ-009 usr_wrequest  input  1  write-side request.
REQ-010 usr_we  input  1  write-side beat strobe.
REQ-011 usr_wlast  input  1  final write beat; qualified by usr_we.
REQ-012 usr_wgrant  output  1  write side owns the user port.
REQ-013 arb_busy  output  1  high in RD or WR state.
REQ-014 arb_err  output  1  sticky protocol-violation flag.

Function
REQ-015 FSM states: IDLE, RD, WR; all outputs are decoded from registered state only: usr_rgrant = (state==RD), usr_wgrant = (state==WR).
REQ-016 usr_rgrant and usr_wgrant are never high in the same cycle.
REQ-017 IDLE: only one side requesting -> grant that side next cycle; neither -> stay IDLE.
REQ-018 IDLE, both requesting: grant the priority side, unless starve_cnt == ARB_STARVE, then grant the non-priority side.
REQ-019 Request-to-grant latency from IDLE: exactly 1 cycle.
REQ-020 RD: burst lock; remain in RD until usr_re && usr_rlast. WR: remain in WR until usr_we && usr_wlast.
REQ-021 Burst-end cycle: the next state is decided with the rules of REQ-017/018 from the requests sampled in that cycle, giving back-to-back grants with zero idle cycles; neither requesting -> IDLE.
REQ-022 Withdrawn request: in RD with no usr_re since entry and usr_rrequest low -> IDLE next cycle; WR with no usr_we since entry and usr_wrequest low -> IDLE. Per-side "started" flag set on first strobe, cleared on state exit.
REQ-023 starve_cnt (4-bit): increments, saturating at ARB_STARVE, on each grant decision that picks the priority side while the non-priority side requests; cleared on any grant to the non-priority side or on a decision where the non-priority side does not request.
REQ-024 Single-beat burst (strobe and last in the entry cycle) ends the burst in that cycle.
REQ-025 arb_err set on: usr_re while not RD, usr_we while not WR, or usr_rlast/usr_wlast high without its strobe; held until reset.
REQ-026 Strobes of the non-owning side never alter state, starve_cnt or started flags.

Reset
REQ-027 usr_reset high at a clock edge: state = IDLE, usr_rgrant = 0, usr_wgrant = 0, arb_busy = 0, arb_err = 0, starve_cnt = 0, started flags = 0.
REQ-028 Reset mid-burst abandons the burst; no grant in the cycle after reset release; arbitration resumes from IDLE.

Verification
REQ-029 ASI_ARB=0, usr_rrequest only at cycle 0 -> usr_rgrant=1 at cycle 1; 4-beat read with usr_rlast on beat 4 -> usr_rgrant=0 the cycle after, arb_busy=0.
REQ-030 ASI_ARB=0, both request continuously, 1-beat bursts, ARB_STARVE=4 -> grant sequence W,W,W,W,R,W,W,W,W,R with no idle cycles between.
REQ-031 RD granted, usr_rrequest dropped before usr_re -> IDLE next cycle; pending usr_wrequest -> usr_wgrant the cycle after.
REQ-032 usr_we pulse while in RD -> arb_err=1 and stays 1; RD burst completes normally.
REQ-033 usr_reset asserted on beat 2 of an 8-beat write -> all outputs 0 next cycle; usr_wrequest still high after release -> usr_wgrant 1 cycle later.

Source files
------------

// File: rtl/asi_arbiter.sv
// ---------------------------------------------------------------------------
// asi_arbiter
//
// Arbitrates ownership of a single user port between a read side and a write
// side. One side is the priority side (ASI_ARB); a starvation counter forces a
// grant to the other side after ARB_STARVE consecutive priority-side wins while
// it waits. Once a side is granted it keeps the port for the whole burst
// (until strobe && last). A granted side that withdraws its request before its
// first strobe gives the port back. Arbitration is re-run in the burst-end
// cycle, so bursts can follow each other with no idle cycle in between.
//
// Parameters
//   ASI_ARB      1 = read side has priority, 0 = write side has priority
//   ARB_STARVE   1..15, max consecutive priority-side grants while the other
//                side is requesting
//
// Ports
//   usr_clk       in   clock, all state updates on the rising edge
//   usr_reset     in   synchronous active-high reset
//   usr_rrequest  in   read side has a burst waiting to start
//   usr_re        in   read beat strobe
//   usr_rlast     in   final read beat (qualified by usr_re)
//   usr_rgrant    out  read side owns the port
//   usr_wrequest  in   write side has a burst waiting to start
//   usr_we        in   write beat strobe
//   usr_wlast     in   final write beat (qualified by usr_we)
//   usr_wgrant    out  write side owns the port
//   arb_busy      out  a burst is granted (RD or WR)
//   arb_err       out  sticky protocol-violation flag
// ---------------------------------------------------------------------------
module asi_arbiter #(
  parameter int unsigned ASI_ARB    = 0,
  parameter int unsigned ARB_STARVE = 4
) (
  input  logic usr_clk,
  input  logic usr_reset,
  input  logic usr_rrequest,
  input  logic usr_re,
  input  logic usr_rlast,
  output logic usr_rgrant,
  input  logic usr_wrequest,
  input  logic usr_we,
  input  logic usr_wlast,
  output logic usr_wgrant,
  output logic arb_busy,
  output logic arb_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(ARB_STARVE);
  localparam bit         RD_PRIO    = (ASI_ARB != 0);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       rd_started_q, rd_started_d;
  logic       wr_started_q, wr_started_d;
  logic       err_q, err_d;

  // Arbitration decision, shared by IDLE and every burst-end cycle.
  logic       prio_req, other_req, starve_hit, pick_other;
  state_e     prio_state, other_state, decide_state;
  logic [3:0] decide_starve;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    prio_req      = RD_PRIO ? usr_rrequest : usr_wrequest;
    other_req     = RD_PRIO ? usr_wrequest : usr_rrequest;
    prio_state    = RD_PRIO ? ST_RD : ST_WR;
    other_state   = RD_PRIO ? ST_WR : ST_RD;
    starve_hit    = (starve_q == STARVE_MAX);
    pick_other    = other_req && (!prio_req || starve_hit);
    decide_state  = ST_IDLE;
    decide_starve = '0;
    if (pick_other) begin
      decide_state = other_state;
    end else if (prio_req) begin
      decide_state = prio_state;
      // Saturation is implicit: at the limit the other side wins instead, so
      // the increment never runs past STARVE_MAX.
      if (other_req) decide_starve = starve_q + 4'd1;
    end
  end

  logic rd_end, wr_end;
  assign rd_end = usr_re && usr_rlast;
  assign wr_end = usr_we && usr_wlast;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    rd_started_d = rd_started_q;
    wr_started_d = wr_started_q;
    err_d        = err_q
                 | (usr_re && (state_q != ST_RD))
                 | (usr_we && (state_q != ST_WR))
                 | (usr_rlast && !usr_re)
                 | (usr_wlast && !usr_we);
    unique case (state_q)
      ST_IDLE: begin
        state_d  = decide_state;
        starve_d = decide_starve;
      end
      ST_RD: begin
        if (rd_end) begin
          state_d      = decide_state;
          starve_d     = decide_starve;
          rd_started_d = 1'b0;
        end else if (!rd_started_q && !usr_re && !usr_rrequest) begin
          // Request withdrawn before the burst ever started.
          state_d      = ST_IDLE;
          rd_started_d = 1'b0;
        end else if (usr_re) begin
          rd_started_d = 1'b1;
        end
      end
      ST_WR: begin
        if (wr_end) begin
          state_d      = decide_state;
          starve_d     = decide_starve;
          wr_started_d = 1'b0;
        end else if (!wr_started_q && !usr_we && !usr_wrequest) begin
          state_d      = ST_IDLE;
          wr_started_d = 1'b0;
        end else if (usr_we) begin
          wr_started_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      rd_started_q <= 1'b0;
      wr_started_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      rd_started_q <= rd_started_d;
      wr_started_q <= wr_started_d;
      err_q        <= err_d;
    end
  end

  assign usr_rgrant = (state_q == ST_RD);
  assign usr_wgrant = (state_q == ST_WR);
  assign arb_busy   = (state_q != ST_IDLE);
  assign arb_err    = err_q;

endmodule
